// File: rtl/dropout_backward.sv
// Backward dropout stage: buffers forward-pass keep masks in a FIFO and applies
// them in order to incoming gradient vectors, zeroing dropped lanes and rescaling kept ones.
module dropout_backward #(
    parameter int LANES       = 8,
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       mask_valid,
    output logic                       mask_ready,
    input  logic [LANES-1:0]           mask_in,
    input  logic                       grad_valid,
    output logic                       grad_ready,
    input  logic [LANES*WIDTH-1:0]     grad_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH+1)-1:0] mask_count,
    output logic                       sat_flag
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int WIDE_W = WIDTH + SCALE_SHIFT;

    // Returns {saturated, value}: the lane shifted left at full width, clipped to WIDTH bits.
    function automatic logic [WIDTH:0] scale_sat(input logic [WIDTH-1:0] g);
        logic [WIDE_W-1:0]    wide;
        logic [SCALE_SHIFT:0] hi;
        wide = {{SCALE_SHIFT{g[WIDTH-1]}}, g} << SCALE_SHIFT;
        hi   = wide[WIDE_W-1:WIDTH-1];
        if ((&hi) || !(|hi)) begin
            scale_sat = {1'b0, wide[WIDTH-1:0]};
        end else if (wide[WIDE_W-1]) begin
            scale_sat = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            scale_sat = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    logic [LANES-1:0]       fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic                   out_valid_r;
    logic [LANES*WIDTH-1:0] out_data_r;
    logic                   sat_r;

    logic                   push_s;
    logic                   pop_s;
    logic [LANES-1:0]       head_mask_s;
    logic [WIDTH:0]         lane_res_s [LANES];
    logic [LANES*WIDTH-1:0] scaled_s;
    logic                   any_sat_s;

    // Handshake qualification; both readies drop while reset is asserted.
    always_comb begin
        mask_ready = 1'b0;
        grad_ready = 1'b0;
        if (enable && !reset) begin
            mask_ready = (count_r < CNT_W'(DEPTH));
            grad_ready = (count_r != {CNT_W{1'b0}}) && (!out_valid_r || out_ready);
        end else begin
            mask_ready = 1'b0;
            grad_ready = 1'b0;
        end
        push_s = mask_valid && mask_ready;
        pop_s  = grad_valid && grad_ready;
    end

    // Per-lane masking and saturating rescale against the FIFO head mask.
    always_comb begin
        head_mask_s = fifo_mem_r[rd_ptr_r];
        scaled_s    = {(LANES*WIDTH){1'b0}};
        any_sat_s   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_res_s[i] = scale_sat(grad_in[i*WIDTH +: WIDTH]);
            if (head_mask_s[i]) begin
                scaled_s[i*WIDTH +: WIDTH] = lane_res_s[i][WIDTH-1:0];
                any_sat_s = any_sat_s | lane_res_s[i][WIDTH];
            end else begin
                scaled_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end
        end
    end

    // Mask storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mask_in;
        end
    end

    // Pointers, occupancy, output register and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {(LANES*WIDTH){1'b0}};
            sat_r       <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            // A new accept wins over a drain so streaming keeps out_valid high.
            if (pop_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= scaled_s;
                if (any_sat_s) begin
                    sat_r <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign mask_count = count_r;
    assign sat_flag   = sat_r;

endmodule

// File: tb/tb_dropout_backward.sv
// Directed bench for dropout_backward: a vector table for the datapath plus
// hand-written sequences for full/empty, wrap ordering, backpressure, enable and reset.
module tb_dropout_backward;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mask_valid;
    logic        mask_ready;
    logic [7:0]  mask_in;
    logic        grad_valid;
    logic        grad_ready;
    logic [63:0] grad_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  mask_count;
    logic        sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  mask;
        logic [63:0] grad;
        logic [63:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs [6];

    dropout_backward dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .mask_in    (mask_in),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_in    (grad_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .mask_count (mask_count),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0]  m;
        logic [63:0] ev;
        int          exp_cnt;

        vecs[0] = '{8'hA5, {8{8'h10}},              64'h2000200000200020, 1'b0};
        vecs[1] = '{8'hFF, 64'h00000000C03FB050,    64'h00000000807E807F, 1'b1};
        vecs[2] = '{8'h0F, {8{8'h81}},              64'h0000000080808080, 1'b1};
        vecs[3] = '{8'hF0, 64'h0807060504030201,    64'h100E0C0A00000000, 1'b1};
        vecs[4] = '{8'h00, {8{8'hFF}},              64'h0000000000000000, 1'b1};
        vecs[5] = '{8'hFF, {8{8'hFF}},              {8{8'hFE}},           1'b1};

        reset = 1'b1; enable = 1'b1; mask_valid = 1'b0; mask_in = 8'h00;
        grad_valid = 1'b0; grad_in = 64'h0; out_ready = 1'b1;
        tick(); tick();
        check("rst_mask_ready", {63'd0, mask_ready}, 64'd0);
        check("rst_grad_ready", {63'd0, grad_ready}, 64'd0);
        check("rst_count", {60'd0, mask_count}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_sat", {63'd0, sat_flag}, 64'd0);
        reset = 1'b0;
        tick();

        // Empty FIFO stalls the gradient
        grad_valid = 1'b1; grad_in = {8{8'h10}};
        for (int c = 0; c < 4; c++) begin
            tick();
            check("empty_grad_ready", {63'd0, grad_ready}, 64'd0);
            check("empty_out_valid", {63'd0, out_valid}, 64'd0);
        end
        grad_valid = 1'b0;

        // Table: push one mask, then apply one gradient
        for (int v = 0; v < 6; v++) begin
            mask_valid = 1'b1; mask_in = vecs[v].mask;
            tick();
            mask_valid = 1'b0;
            check("vec_count_after_push", {60'd0, mask_count}, 64'd1);
            grad_valid = 1'b1; grad_in = vecs[v].grad;
            tick();
            grad_valid = 1'b0;
            check("vec_out_valid", {63'd0, out_valid}, 64'd1);
            check("vec_out_data", out_data, vecs[v].exp_data);
            check("vec_sat", {63'd0, sat_flag}, {63'd0, vecs[v].exp_sat});
            check("vec_count_after_pop", {60'd0, mask_count}, 64'd0);
        end
        tick();

        // Fill the FIFO with single-lane masks
        for (int i = 0; i < 8; i++) begin
            mask_valid = 1'b1;
            m = 8'h01 << i;
            mask_in = m;
            tick();
        end
        mask_in = 8'hFF;
        check("full_count", {60'd0, mask_count}, 64'd8);
        check("full_mask_ready", {63'd0, mask_ready}, 64'd0);
        tick(); tick();
        check("full_hold_count", {60'd0, mask_count}, 64'd8);

        // Drain 16 vectors while refilling 8 masks so both pointers wrap
        grad_in = {8{8'h01}};
        for (int e = 1; e <= 16; e++) begin
            grad_valid = 1'b1;
            mask_valid = (e <= 9);
            if (e == 1) begin
                mask_in = 8'hFF;
            end else begin
                m = 8'h01 << (e - 2);
                mask_in = m;
            end
            tick();
            ev = 64'h02 << (8 * ((e - 1) % 8));
            exp_cnt = (e <= 9) ? 7 : 16 - e;
            check("wrap_out_valid", {63'd0, out_valid}, 64'd1);
            check("wrap_out_data", out_data, ev);
            check("wrap_count", {60'd0, mask_count}, 64'(exp_cnt));
            if (e == 1) begin
                check("slot_freed_mask_ready", {63'd0, mask_ready}, 64'd1);
            end
        end
        grad_valid = 1'b0; mask_valid = 1'b0;
        tick();
        check("drained_out_valid", {63'd0, out_valid}, 64'd0);
        check("drained_grad_ready", {63'd0, grad_ready}, 64'd0);

        // Backpressure: output held, gradient stalled, then streaming without bubbles
        mask_valid = 1'b1; mask_in = 8'hFF;
        tick(); tick(); tick();
        mask_valid = 1'b0;
        out_ready = 1'b0; grad_valid = 1'b1; grad_in = {8{8'h11}};
        tick();
        check("bp_first_out", out_data, {8{8'h22}});
        grad_in = {8{8'h12}};
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_data", out_data, {8{8'h22}});
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_grad_ready", {63'd0, grad_ready}, 64'd0);
            check("bp_count", {60'd0, mask_count}, 64'd2);
        end
        out_ready = 1'b1;
        tick();
        check("stream1_valid", {63'd0, out_valid}, 64'd1);
        check("stream1_data", out_data, {8{8'h24}});
        grad_in = {8{8'h13}};
        tick();
        check("stream2_valid", {63'd0, out_valid}, 64'd1);
        check("stream2_data", out_data, {8{8'h26}});
        check("stream_count", {60'd0, mask_count}, 64'd0);
        grad_valid = 1'b0;
        tick();
        check("stream_end_valid", {63'd0, out_valid}, 64'd0);

        // Enable low blocks pushes and accepts
        mask_valid = 1'b1; mask_in = 8'hFF;
        tick(); tick();
        enable = 1'b0; grad_valid = 1'b1; grad_in = {8{8'h7F}};
        for (int c = 0; c < 4; c++) begin
            tick();
            check("en_count", {60'd0, mask_count}, 64'd2);
            check("en_out_valid", {63'd0, out_valid}, 64'd0);
            check("en_mask_ready", {63'd0, mask_ready}, 64'd0);
            check("en_grad_ready", {63'd0, grad_ready}, 64'd0);
        end
        enable = 1'b1; grad_valid = 1'b0;
        tick(); tick();
        mask_valid = 1'b0;
        check("pre_rst_count", {60'd0, mask_count}, 64'd4);
        out_ready = 1'b0; grad_valid = 1'b1;
        tick();
        grad_valid = 1'b0;
        check("pre_rst_pending", {63'd0, out_valid}, 64'd1);
        check("pre_rst_sat_data", out_data, {8{8'h7F}});

        // Mid-operation reset discards masks and the pending output
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count", {60'd0, mask_count}, 64'd0);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_sat", {63'd0, sat_flag}, 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        out_ready = 1'b1;
        #1;
        check("mid_rst_grad_ready", {63'd0, grad_ready}, 64'd0);
        tick();
        mask_valid = 1'b1; mask_in = 8'h01;
        tick();
        mask_valid = 1'b0; grad_valid = 1'b1; grad_in = {8{8'h05}};
        tick();
        grad_valid = 1'b0;
        check("post_rst_data", out_data, 64'h000000000000000A);
        check("post_rst_count", {60'd0, mask_count}, 64'd0);
        check("post_rst_sat", {63'd0, sat_flag}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dropout_backward.md
Name: dropout_backward

Overview:
Backward-pass companion to the forward random-dropout stage. Buffers the per-lane keep masks produced by the forward pass in a FIFO, then applies each mask, in order, to an incoming gradient vector. Dropped lanes are zeroed and kept lanes are rescaled by 2^SCALE_SHIFT with signed saturation. Sits between the gradient source and the upstream-layer gradient sink, using valid/ready handshakes on all three streams.

Parameters:
LANES, 8, number of elements per vector and number of mask bits per entry
WIDTH, 8, bits per element, signed two's complement
DEPTH, 8, mask FIFO entries; power of two, >= 2
SCALE_SHIFT, 1, left-shift applied to kept lanes (1 corresponds to p = 0.5)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  high = accept mask and gradient inputs; low = input stall
mask_valid  in  1  mask_in valid
mask_ready  out  1  FIFO can accept a mask
mask_in  in  LANES  keep mask; bit i = 1 keeps lane i
grad_valid  in  1  grad_in valid
grad_ready  out  1  gradient accepted this cycle when grad_valid is also high
grad_in  in  LANES*WIDTH  gradient vector; lane i = bits [i*WIDTH +: WIDTH]
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  LANES*WIDTH  masked and scaled gradient
mask_count  out  clog2(DEPTH+1)  current FIFO occupancy
sat_flag  out  1  sticky: at least one lane has saturated since reset

Behaviour:
- Reset, sampled on a clk edge with reset = 1:
  - FIFO read/write pointers, mask_count, out_valid, out_data and sat_flag all go to 0.
  - mask_ready and grad_ready are forced to 0 while reset is high.
- mask_ready = enable && !reset && (mask_count < DEPTH).
  - A push occurs on mask_valid && mask_ready.
  - When full, pushes are blocked even if a pop happens in the same cycle.
- grad_ready = enable && !reset && (mask_count != 0) && (!out_valid || out_ready).
  - An accept occurs on grad_valid && grad_ready. It pops the FIFO head mask.
- A mask pushed in cycle N is counted in mask_count from N+1 and is first usable by a gradient in N+1. There is no same-cycle bypass.
- Simultaneous push and pop: mask_count is unchanged; both pointers advance and wrap modulo DEPTH.
- Datapath: one output register; latency is 1 cycle from accept to out_valid. For each lane i:
  - mask bit = 0: output 0.
  - mask bit = 1: compute the signed grad << SCALE_SHIFT at full width, then saturate to WIDTH bits. Range is [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- sat_flag is set in the cycle after an accept in which any kept lane clipped. It clears only on reset.
- Output handshake:
  - An accept loads out_data and sets out_valid.
  - out_valid && out_ready with no new accept clears out_valid.
  - An accept in the same cycle as out_ready keeps out_valid = 1 and loads the new data. This gives full throughput of 1 vector per cycle.
  - While out_valid && !out_ready, out_data is held stable and grad_ready = 0.
- enable = 0:
  - No pushes and no accepts.
  - The pending output may still drain through out_ready.
  - FIFO contents and sat_flag are preserved.
- Ordering: masks are applied strictly in push order, one mask per gradient vector. Each mask is never reused or skipped.
- The gradient is stalled (grad_ready = 0) whenever the FIFO is empty. This is not an error condition.
- Reset mid-operation discards all buffered masks and any pending output. It takes effect at the next edge.

Test Plan:
- Basic masking (defaults), all lanes 8'h10: push mask 8'b1010_0101, then present grad.
  - Next cycle out_valid = 1.
  - Lanes 0, 2, 5, 7 = 8'h20; lanes 1, 3, 4, 6 = 8'h00; mask_count goes 1 -> 0.
- Saturation: mask 8'hFF, lane0 = 8'h50, lane1 = 8'hB0, lane2 = 8'h3F, lane3 = 8'hC0, others 0.
  - Out: lane0 = 8'h7F, lane1 = 8'h80, lane2 = 8'h7E, lane3 = 8'h80.
  - sat_flag = 1 and stays 1 after later unsaturated vectors.
- Full / empty:
  - grad_valid = 1 with an empty FIFO -> grad_ready = 0 indefinitely.
  - Push 8 masks -> mask_count = 8, mask_ready = 0, and a 9th mask_valid is held off.
  - One accept frees a slot; mask_ready = 1 next cycle.
- Order and wrap: push masks 01, 02, 04 ... 80 and then 8 more (interleaved with accepts so the pointers wrap).
  - Each output vector has exactly the corresponding single lane non-zero, in push order.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1.
  - out_data stays constant and grad_ready = 0.
  - On out_ready = 1 with grad_valid = 1, back-to-back vectors stream with no bubble.
- Reset and enable:
  - enable = 0 for 4 cycles with valid inputs -> no pushes or accepts, mask_count unchanged.
  - After 3 pushes and one pending output, assert reset for 1 cycle -> mask_count = 0, out_valid = 0, sat_flag = 0, and the old masks are never applied.
